// File: rtl/video_bus_arbiter.sv
// Bus arbiter between the i8080 and the video fetcher: takes the bus via HOLD/HLDA, reads one byte (or a burst), hands the bus back.
// Define VIDEO_BUS_ARBITER_BURST_EN to allow up to BURST_MAX beats per hold tenure; otherwise one beat per tenure.
module video_bus_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LAT     = 1,
   parameter int HOLD_TIMEOUT = 64,
   parameter int BURST_MAX    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic                  vid_ack,
   output logic [DATA_WIDTH-1:0] vid_data,
   output logic                  cpu_hold,
   input  logic                  cpu_hlda,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_addr_en,
   output logic                  mem_oe_n,
   input  logic [DATA_WIDTH-1:0] bus_data,
   output logic                  timeout,
   output logic                  busy
);

   // state     | meaning
   // S_IDLE    | bus owned by CPU, waiting for a fetch request
   // S_HOLD    | hold asserted, waiting for hlda (bounded by HOLD_TIMEOUT)
   // S_READ    | driving address with mem_oe_n low for READ_LAT cycles
   // S_ACK     | vid_ack pulse, fetched byte on vid_data
   // S_NEXT    | choose another beat or release the bus
   // S_RELEASE | hold dropped, waiting for hlda to fall

   localparam int WAIT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
   localparam int RD_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int BEAT_W = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;

`ifdef VIDEO_BUS_ARBITER_BURST_EN
   localparam int BEAT_LIMIT = BURST_MAX;
`else
   localparam int BEAT_LIMIT = 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_READ,
      S_ACK,
      S_NEXT,
      S_RELEASE
   } state_t;

   state_t              state, state_nx;
   logic [WAIT_W-1:0]   wait_cnt, wait_nx;
   logic [RD_W-1:0]     rd_cnt, rd_nx;
   logic [BEAT_W-1:0]   beat_cnt, beat_nx;
   logic                capture;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         rd_cnt   <= '0;
         beat_cnt <= '0;
         vid_data <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         rd_cnt   <= rd_nx;
         beat_cnt <= beat_nx;
         if (capture) begin
            vid_data <= bus_data;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      wait_nx     = wait_cnt;
      rd_nx       = rd_cnt;
      beat_nx     = beat_cnt;
      capture     = 1'b0;
      cpu_hold    = 1'b0;
      bus_addr_en = 1'b0;
      bus_addr    = '0;
      mem_oe_n    = 1'b1;
      vid_ack     = 1'b0;
      timeout     = 1'b0;
      busy        = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            wait_nx = '0;
            rd_nx   = '0;
            beat_nx = '0;
            if (vid_req) begin
               state_nx = S_HOLD;
            end
         end

         S_HOLD: begin
            cpu_hold = 1'b1;
            // hlda in the last wait cycle still wins over the timeout
            if (cpu_hlda) begin
               state_nx = S_READ;
               wait_nx  = '0;
               rd_nx    = '0;
               beat_nx  = '0;
            end else if (wait_cnt == WAIT_W'(HOLD_TIMEOUT - 1)) begin
               timeout  = 1'b1;
               wait_nx  = '0;
               state_nx = S_IDLE;
            end else begin
               wait_nx = wait_cnt + WAIT_W'(1);
            end
         end

         S_READ: begin
            cpu_hold    = 1'b1;
            bus_addr_en = 1'b1;
            bus_addr    = vid_addr;
            mem_oe_n    = 1'b0;
            if (!cpu_hlda) begin
               rd_nx    = '0;
               state_nx = S_RELEASE;
            end else if (rd_cnt == RD_W'(READ_LAT - 1)) begin
               capture  = 1'b1;
               rd_nx    = '0;
               state_nx = S_ACK;
            end else begin
               rd_nx = rd_cnt + RD_W'(1);
            end
         end

         S_ACK: begin
            cpu_hold    = 1'b1;
            bus_addr_en = 1'b1;
            bus_addr    = vid_addr;
            vid_ack     = 1'b1;
            beat_nx     = beat_cnt + BEAT_W'(1);
            state_nx    = cpu_hlda ? S_NEXT : S_RELEASE;
         end

         S_NEXT: begin
            cpu_hold    = 1'b1;
            bus_addr_en = 1'b1;
            bus_addr    = vid_addr;
            // beat_cnt is at least 1 here, so a limit of 1 always releases
            if (cpu_hlda && vid_req && (beat_cnt < BEAT_W'(BEAT_LIMIT))) begin
               rd_nx    = '0;
               state_nx = S_READ;
            end else begin
               state_nx = S_RELEASE;
            end
         end

         S_RELEASE: begin
            if (!cpu_hlda) begin
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Scoreboard bench for video_bus_arbiter: two instances (READ_LAT=1 and READ_LAT=3), directed vectors.
module tb_video_bus_arbiter;

   logic        clk;
   logic        rst;

   logic        vid_req, vid_ack, cpu_hold, cpu_hlda, bus_addr_en, mem_oe_n, timeout, busy;
   logic [15:0] vid_addr, bus_addr;
   logic [7:0]  vid_data, bus_data;
   logic        hlda_auto;

   logic        vid_req3, vid_ack3, cpu_hold3, cpu_hlda3, bus_addr_en3, mem_oe_n3, timeout3, busy3;
   logic [15:0] vid_addr3, bus_addr3;
   logic [7:0]  vid_data3, bus_data3;
   logic        hlda_auto3;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  exp_q3[$];
   logic [15:0] req_next[$];
   int          ten_acks[$];
   logic        ack_pend = 1'b0;
   logic        hold_prev = 1'b0;
   logic [7:0]  exp_v, exp_v3;

   function automatic logic [7:0] fmem(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h81;
   endfunction

   assign cpu_hlda  = hlda_auto & cpu_hold;
   assign cpu_hlda3 = hlda_auto3 & cpu_hold3;
   assign bus_data  = fmem(bus_addr);
   assign bus_data3 = fmem(bus_addr3);

   video_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LAT(1), .HOLD_TIMEOUT(8), .BURST_MAX(4)) dut (
      .clk(clk), .rst(rst), .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_data(vid_data), .cpu_hold(cpu_hold), .cpu_hlda(cpu_hlda), .bus_addr(bus_addr),
      .bus_addr_en(bus_addr_en), .mem_oe_n(mem_oe_n), .bus_data(bus_data),
      .timeout(timeout), .busy(busy)
   );

   video_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LAT(3), .HOLD_TIMEOUT(8), .BURST_MAX(4)) dut3 (
      .clk(clk), .rst(rst), .vid_req(vid_req3), .vid_addr(vid_addr3), .vid_ack(vid_ack3),
      .vid_data(vid_data3), .cpu_hold(cpu_hold3), .cpu_hlda(cpu_hlda3), .bus_addr(bus_addr3),
      .bus_addr_en(bus_addr_en3), .mem_oe_n(mem_oe_n3), .bus_data(bus_data3),
      .timeout(timeout3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: pops expected bytes on every ack, tracks hold tenures
   always @(negedge clk) begin
      ack_pend = vid_ack;
      if (vid_ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: got ack with data %0h, required no ack (t=%0t)", vid_data, $time);
         end else begin
            exp_v = exp_q.pop_front();
            chk("ack_data", 32'(vid_data), 32'(exp_v));
         end
      end
      if (vid_ack3) begin
         if (exp_q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack3_unexpected: got ack with data %0h, required no ack (t=%0t)", vid_data3, $time);
         end else begin
            exp_v3 = exp_q3.pop_front();
            chk("ack3_data", 32'(vid_data3), 32'(exp_v3));
         end
      end
      if (cpu_hold && !hold_prev) ten_acks.push_back(0);
      if (vid_ack && ten_acks.size() > 0) ten_acks[ten_acks.size()-1] += 1;
      hold_prev = cpu_hold;
   end

   // requester: next address (or drop) in the cycle after each ack
   always @(posedge clk) begin
      if (ack_pend) begin
         #1;
         if (req_next.size() > 0) vid_addr = req_next.pop_front();
         else vid_req = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  t_hold, t_oen, t_en, t_ack, t_busy;
      logic [11:0] t3_hold, t3_oen, t3_ack;
      int          n;
      int          bad;

      rst = 1'b1; vid_req = 1'b0; vid_addr = '0; hlda_auto = 1'b1;
      vid_req3 = 1'b0; vid_addr3 = '0; hlda_auto3 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'(0));
      chk("rst_bus_addr_en", 32'(bus_addr_en), 32'(0));
      chk("rst_bus_addr", 32'(bus_addr), 32'(0));
      chk("rst_mem_oe_n", 32'(mem_oe_n), 32'(1));
      chk("rst_vid_ack", 32'(vid_ack), 32'(0));
      chk("rst_vid_data", 32'(vid_data), 32'(0));
      chk("rst_timeout", 32'(timeout), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));

      // single read, READ_LAT=1, hlda in cycle 1 -> ack in cycle 3
      t_hold = 7'b0011110; t_oen = 7'b1111011; t_en = 7'b0011100;
      t_ack  = 7'b0001000; t_busy = 7'b0111110;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            vid_addr = 16'h2400; vid_req = 1'b1; exp_q.push_back(8'hA5);
         end
         @(negedge clk);
         chk($sformatf("sr_hold_c%0d", c), 32'(cpu_hold), 32'(t_hold[c]));
         chk($sformatf("sr_oe_n_c%0d", c), 32'(mem_oe_n), 32'(t_oen[c]));
         chk($sformatf("sr_addr_en_c%0d", c), 32'(bus_addr_en), 32'(t_en[c]));
         chk($sformatf("sr_ack_c%0d", c), 32'(vid_ack), 32'(t_ack[c]));
         chk($sformatf("sr_busy_c%0d", c), 32'(busy), 32'(t_busy[c]));
         if (c == 2) chk("sr_bus_addr", 32'(bus_addr), 32'(16'h2400));
         if (c == 3) chk("sr_vid_data", 32'(vid_data), 32'(8'hA5));
         if (c == 6) chk("sr_bus_addr_idle", 32'(bus_addr), 32'(0));
      end

      // burst of 6 addresses
      @(posedge clk); #1;
      ten_acks.delete();
      req_next = '{16'h2401, 16'h2402, 16'h2403, 16'h2404, 16'h2405};
      exp_q.push_back(8'hA5); exp_q.push_back(8'hA4); exp_q.push_back(8'hA7);
      exp_q.push_back(8'hA6); exp_q.push_back(8'hA1); exp_q.push_back(8'hA0);
      vid_addr = 16'h2400; vid_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while ((vid_req || busy) && n < 300);
      chk("burst_completion", 32'(vid_req | busy), 32'(0));
      chk("burst_exp_empty", 32'(exp_q.size()), 32'(0));
`ifdef VIDEO_BUS_ARBITER_BURST_EN
      chk("burst_tenures", 32'(ten_acks.size()), 32'(2));
      if (ten_acks.size() == 2) begin
         chk("burst_ten0_acks", 32'(ten_acks[0]), 32'(4));
         chk("burst_ten1_acks", 32'(ten_acks[1]), 32'(2));
      end
`else
      chk("burst_tenures", 32'(ten_acks.size()), 32'(6));
      if (ten_acks.size() == 6) begin
         chk("burst_ten0_acks", 32'(ten_acks[0]), 32'(1));
         chk("burst_ten5_acks", 32'(ten_acks[5]), 32'(1));
      end
`endif

      // timeout, retry, then hlda arriving in the timeout cycle wins
      hlda_auto = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            vid_addr = 16'h1234; vid_req = 1'b1; exp_q.push_back(8'hA7);
         end
         if (c == 17) hlda_auto = 1'b1;
         @(negedge clk);
         chk($sformatf("to_timeout_c%0d", c), 32'(timeout), 32'(c == 8));
         if (c != 8)
            chk($sformatf("to_hold_c%0d", c), 32'(cpu_hold), 32'((c >= 1 && c <= 7) || c >= 10));
         chk($sformatf("to_oe_n_c%0d", c), 32'(mem_oe_n), 32'(c != 18));
         chk($sformatf("to_ack_c%0d", c), 32'(vid_ack), 32'(c == 19));
         if (c == 9) chk("to_busy_idle", 32'(busy), 32'(0));
      end
      repeat (4) @(negedge clk);
      chk("to_exp_empty", 32'(exp_q.size()), 32'(0));

      // hlda lost in 2nd READ cycle of READ_LAT=3 instance, then retry
      t3_hold = 12'b111111001110; t3_oen = 12'b110001110011; t3_ack = 12'b010000000000;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            vid_addr3 = 16'h3C00; vid_req3 = 1'b1; exp_q3.push_back(8'hBD);
         end
         if (c == 3) hlda_auto3 = 1'b0;
         if (c == 4) hlda_auto3 = 1'b1;
         if (c == 11) vid_req3 = 1'b0;
         @(negedge clk);
         chk($sformatf("hl_hold_c%0d", c), 32'(cpu_hold3), 32'(t3_hold[c]));
         chk($sformatf("hl_oe_n_c%0d", c), 32'(mem_oe_n3), 32'(t3_oen[c]));
         chk($sformatf("hl_ack_c%0d", c), 32'(vid_ack3), 32'(t3_ack[c]));
         if (c == 4) chk("hl_addr_en_release", 32'(bus_addr_en3), 32'(0));
      end
      repeat (4) @(negedge clk);
      chk("hl_exp_empty", 32'(exp_q3.size()), 32'(0));

      // reset asserted in the READ cycle
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            vid_addr = 16'h2402; vid_req = 1'b1;
         end
         if (c == 2) rst = 1'b1;
         if (c == 3) begin
            rst = 1'b0; vid_req = 1'b0;
         end
         @(negedge clk);
         if (c == 2) chk("rr_in_read", 32'(mem_oe_n), 32'(0));
         if (c == 3) begin
            chk("rr_cpu_hold", 32'(cpu_hold), 32'(0));
            chk("rr_bus_addr_en", 32'(bus_addr_en), 32'(0));
            chk("rr_bus_addr", 32'(bus_addr), 32'(0));
            chk("rr_mem_oe_n", 32'(mem_oe_n), 32'(1));
            chk("rr_vid_data", 32'(vid_data), 32'(0));
         end
         if (c >= 3) chk($sformatf("rr_busy_c%0d", c), 32'(busy), 32'(0));
      end

      // idle bus for 100 cycles
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (cpu_hold || bus_addr_en || timeout || !mem_oe_n) bad++;
      end
      chk("idle_bad_cycles", 32'(bad), 32'(0));
      chk("final_exp_empty", 32'(exp_q.size() + exp_q3.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
